// File: rtl/exe_mdu_unit_if.sv
// rtl/exe_mdu_unit_if.sv - operand/result bundle between the EXE stage and the multiply/divide unit
interface exe_mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             op_valid;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             exe_stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, op_valid, op_code, src_a, src_b,
    input  exe_stall, busy, done, hi, lo
  );

  modport slave (
    input  flush, op_valid, op_code, src_a, src_b,
    output exe_stall, busy, done, hi, lo
  );
endinterface

// File: rtl/exe_mdu_unit.sv
// rtl/exe_mdu_unit.sv - EXE multiply/divide unit with HI/LO; define MDU_MADD_EN to enable MADD(U)/MSUB(U)
module exe_mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  exe_mdu_unit_if.slave mdu
);
  localparam int            CW       = $clog2(WIDTH + MUL_STAGES + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  // a_q: multiplicand, or dividend magnitude that shifts into the quotient
  logic [WIDTH-1:0]   a_q, a_d;
  // b_q: multiplier, or divisor magnitude
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;

  logic               in_mul, in_div, in_mt, in_signed, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_src, mul_res;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic               op_q_div;
  logic [WIDTH-1:0]   div_lo, div_hi;

  // decode the op presented in EXE and decide whether it is taken this cycle
  always_comb begin
    in_mul = 1'b0;
    in_div = 1'b0;
    in_mt  = 1'b0;
    case (mdu.op_code)
      4'h1, 4'h2: in_mul = 1'b1;
`ifdef MDU_MADD_EN
      4'h5, 4'h6, 4'h7, 4'h8: in_mul = 1'b1;
`endif
      4'h3, 4'h4: in_div = 1'b1;
      4'h9, 4'hA: in_mt = 1'b1;
      default: ;
    endcase
    // odd opcodes among the arithmetic ops are the signed variants
    in_signed = mdu.op_code[0];
    accept    = mdu.op_valid & (state_q == S_IDLE) & ~mdu.flush & ~rst
              & (in_mul | in_div | in_mt);
    mag_a     = (in_signed & mdu.src_a[WIDTH-1]) ? -mdu.src_a : mdu.src_a;
    mag_b     = (in_signed & mdu.src_b[WIDTH-1]) ? -mdu.src_b : mdu.src_b;
  end

  // product, accumulate and divider step from the latched operands
  always_comb begin
    ext_a    = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b    = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod     = ext_a * ext_b;
    // single-stage multiplier has no pipeline register to read from
    mul_src  = (MUL_STAGES > 1) ? prod_q : prod;
`ifdef MDU_MADD_EN
    case (op_q)
      4'h5, 4'h6: mul_res = {hi_q, lo_q} + mul_src;
      4'h7, 4'h8: mul_res = {hi_q, lo_q} - mul_src;
      default:    mul_res = mul_src;
    endcase
`else
    mul_res  = mul_src;
`endif
    // restoring radix-2 step: bring down the next dividend bit and try to subtract
    div_sh   = {rem_q, a_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_rem  = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
    op_q_div = (op_q == 4'h3) | (op_q == 4'h4);
    // a zero divisor leaves an all-ones quotient regardless of sign
    div_lo   = bzero_q ? {WIDTH{1'b1}} : (qneg_q ? -a_q : a_q);
    div_hi   = rneg_q ? -rem_q : rem_q;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept & in_mul)      state_d = (MUL_STAGES == 1) ? S_DONE : S_MUL;
        else if (accept & in_div) state_d = S_DIV;
      end
      S_MUL: begin
        if (mdu.flush)              state_d = S_IDLE;
        else if (cnt_q == MUL_LAST) state_d = S_DONE;
      end
      S_DIV: begin
        if (mdu.flush)              state_d = S_IDLE;
        else if (cnt_q == DIV_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // handshake outputs; done is suppressed by a flush in the completing cycle
  always_comb begin
    mdu.busy      = (state_q != S_IDLE);
    mdu.exe_stall = (state_q == S_MUL) | (state_q == S_DIV) | (accept & ~in_mt);
    mdu.done      = ((state_q == S_DONE) & ~mdu.flush) | (accept & in_mt);
    mdu.hi        = hi_q;
    mdu.lo        = lo_q;
  end

  // datapath next values: operand capture, iteration and HI/LO writeback
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    if (state_q == S_IDLE) begin
      cnt_d = CW'(1);
      if (accept) begin
        op_d = mdu.op_code;
        if (in_div) begin
          a_d     = mag_a;
          b_d     = mag_b;
          rem_d   = '0;
          qneg_d  = in_signed & (mdu.src_a[WIDTH-1] ^ mdu.src_b[WIDTH-1]);
          rneg_d  = in_signed & mdu.src_a[WIDTH-1];
          bzero_d = (mdu.src_b == '0);
        end else begin
          a_d = mdu.src_a;
          b_d = mdu.src_b;
        end
        if (in_mt & mdu.op_code[0])  hi_d = mdu.src_a;
        if (in_mt & ~mdu.op_code[0]) lo_d = mdu.src_a;
      end
    end
    if (state_q == S_MUL) prod_d = prod;
    if (state_q == S_DIV) begin
      rem_d = div_rem;
      a_d   = {a_q[WIDTH-2:0], div_ge};
    end
    if ((state_q == S_DONE) & ~mdu.flush) begin
      if (op_q_div) begin
        hi_d = div_hi;
        lo_d = div_lo;
      end else begin
        {hi_d, lo_d} = mul_res;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
    end
  end
endmodule
